// File: rtl/reg_writeback_if.sv
// Bundle for the register-file write-side controller: intake handshakes, write strobe,
// status and forwarding lookup.
interface reg_writeback_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              init;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_reg;
  logic [DATA_W-1:0] ld_data;
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              RegWrite;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeValue;
  logic              pending;
  logic [7:0]        drop_cnt;
  logic [ADDR_W-1:0] fwd_reg;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  modport master (
    output init, ld_valid, ld_reg, ld_data, alu_valid, alu_reg, alu_data, fwd_reg,
    input  ld_ready, alu_ready, RegWrite, writeReg, writeValue, pending, drop_cnt,
           fwd_hit, fwd_data
  );

  modport slave (
    input  init, ld_valid, ld_reg, ld_data, alu_valid, alu_reg, alu_data, fwd_reg,
    output ld_ready, alu_ready, RegWrite, writeReg, writeValue, pending, drop_cnt,
           fwd_hit, fwd_data
  );
endinterface

// File: rtl/reg_writeback.sv
// Register-file write-side controller: filters protected destinations, queues results and
// issues one-cycle write strobes. Optional forwarding lookup enabled by WB_FWD_EN.
module reg_writeback #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input logic           CLK,
  input logic           RST_N,
  reg_writeback_if.slave wb
);
  localparam int PW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [PW:0]       wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] q_reg  [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [ADDR_W-1:0] wr_reg_q;
  logic [DATA_W-1:0] wr_val_q;
  logic [7:0]        drop_q;

  logic              empty, full;
  logic              ld_acc, alu_acc, acc, prot, push, pop;
  logic [ADDR_W-1:0] in_reg;
  logic [DATA_W-1:0] in_data;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  // Load wins arbitration; readiness ignores a same-cycle pop.
  assign wb.ld_ready  = !full;
  assign wb.alu_ready = !full && !wb.ld_valid;
  assign ld_acc       = wb.ld_valid && !full;
  assign alu_acc      = wb.alu_valid && !full && !wb.ld_valid;
  assign acc          = ld_acc || alu_acc;
  assign in_reg       = ld_acc ? wb.ld_reg  : wb.alu_reg;
  assign in_data      = ld_acc ? wb.ld_data : wb.alu_data;

  assign prot = in_reg inside {ADDR_W'(7), ADDR_W'(9), ADDR_W'(10), ADDR_W'(11),
                               ADDR_W'(12), ADDR_W'(13)};
  assign push = acc && !prot;
  assign pop  = !empty && !wb.init;

  always_comb begin
    state_nxt = S_IDLE;
    if (pop)         state_nxt = S_ISSUE;
    else if (!empty) state_nxt = S_HOLD;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_reg_q <= '0;
      wr_val_q <= '0;
      drop_q   <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        wr_reg_q <= q_reg[rd_ptr[PW-1:0]];
        wr_val_q <= q_data[rd_ptr[PW-1:0]];
      end
      if (acc && prot && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge CLK) begin
    if (push) begin
      q_reg[wr_ptr[PW-1:0]]  <= in_reg;
      q_data[wr_ptr[PW-1:0]] <= in_data;
    end
  end

  assign wb.RegWrite   = (state == S_ISSUE);
  assign wb.writeReg   = wr_reg_q;
  assign wb.writeValue = wr_val_q;
  assign wb.drop_cnt   = drop_q;
  assign wb.pending    = !empty || (state == S_ISSUE);

`ifdef WB_FWD_EN
  logic [PW:0]   count;
  logic [PW-1:0] fidx;
  logic          hit;
  logic [DATA_W-1:0] fdata;

  assign count = wr_ptr - rd_ptr;

  // Scan oldest to youngest so the youngest match overrides; the strobe is oldest of all.
  always_comb begin
    hit   = 1'b0;
    fdata = '0;
    fidx  = '0;
    if (state == S_ISSUE && wr_reg_q == wb.fwd_reg) begin
      hit   = 1'b1;
      fdata = wr_val_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      fidx = rd_ptr[PW-1:0] + PW'(i);
      if ((PW+1)'(i) < count && q_reg[fidx] == wb.fwd_reg) begin
        hit   = 1'b1;
        fdata = q_data[fidx];
      end
    end
  end

  assign wb.fwd_hit  = hit;
  assign wb.fwd_data = fdata;
`else
  logic unused_fwd;
  assign unused_fwd  = ^wb.fwd_reg;
  assign wb.fwd_hit  = 1'b0;
  assign wb.fwd_data = '0;
`endif
endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed scenarios plus randomized traffic checked every cycle
// against a queue-based reference model.
module tb_reg_writeback;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  reg_writeback_if #(.DATA_W(16), .ADDR_W(4)) wb();
  reg_writeback #(.DATA_W(16), .ADDR_W(4), .DEPTH(4)) dut (.CLK(CLK), .RST_N(RST_N), .wb(wb));

  typedef struct { logic [3:0] r; logic [15:0] d; } ent_t;
  ent_t        mq[$];
  bit          m_rw = 0;
  logic [3:0]  m_wr = '0;
  logic [15:0] m_wv = '0;
  int          m_drop = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_prot(input logic [3:0] r);
    return (r == 7) || (r >= 9 && r <= 13);
  endfunction

  // Reference model: one acceptance and at most one issue per edge.
  initial begin
    forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) begin
        mq.delete(); m_rw = 0; m_wr = '0; m_wv = '0; m_drop = 0;
      end else begin
        int sz;
        bit lacc, aacc;
        logic [3:0]  r;
        logic [15:0] d;
        sz   = mq.size();
        lacc = wb.ld_valid && sz < 4;
        aacc = wb.alu_valid && !wb.ld_valid && sz < 4;
        r    = lacc ? wb.ld_reg  : wb.alu_reg;
        d    = lacc ? wb.ld_data : wb.alu_data;
        if (sz > 0 && !wb.init) begin
          m_rw = 1; m_wr = mq[0].r; m_wv = mq[0].d;
          void'(mq.pop_front());
        end else m_rw = 0;
        if (lacc || aacc) begin
          if (is_prot(r)) begin
            if (m_drop < 255) m_drop++;
          end else mq.push_back('{r: r, d: d});
        end
      end
    end
  end

  // Every-cycle comparison away from the active edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST_N) begin
        bit          ehit;
        logic [15:0] edata;
        ehit = 0; edata = '0;
`ifdef WB_FWD_EN
        if (m_rw && m_wr == wb.fwd_reg) begin ehit = 1; edata = m_wv; end
        foreach (mq[i]) if (mq[i].r == wb.fwd_reg) begin ehit = 1; edata = mq[i].d; end
`endif
        chk("RegWrite",   wb.RegWrite,   m_rw);
        if (m_rw) begin
          chk("writeReg",   wb.writeReg,   m_wr);
          chk("writeValue", wb.writeValue, m_wv);
        end
        chk("pending",   wb.pending,   (mq.size() > 0) || m_rw);
        chk("drop_cnt",  wb.drop_cnt,  m_drop);
        chk("ld_ready",  wb.ld_ready,  mq.size() < 4);
        chk("alu_ready", wb.alu_ready, (mq.size() < 4) && !wb.ld_valid);
        chk("fwd_hit",   wb.fwd_hit,   ehit);
        chk("fwd_data",  wb.fwd_data,  edata);
      end
    end
  end

  task automatic step;
    @(posedge CLK); #1;
  endtask

  task automatic idle_in;
    wb.ld_valid = 0; wb.alu_valid = 0; wb.init = 0;
  endtask

  initial begin
    wb.init = 0; wb.ld_valid = 0; wb.ld_reg = '0; wb.ld_data = '0;
    wb.alu_valid = 0; wb.alu_reg = '0; wb.alu_data = '0; wb.fwd_reg = '0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_RegWrite", wb.RegWrite, 0);
    chk("rst_writeReg", wb.writeReg, 0);
    chk("rst_writeValue", wb.writeValue, 0);
    chk("rst_drop", wb.drop_cnt, 0);
    #2 RST_N = 1;
    #1;
    chk("rst_ld_ready", wb.ld_ready, 1);
    chk("rst_alu_ready", wb.alu_ready, 1);
    step;

    // Load beats ALU in the same cycle
    wb.ld_valid = 1; wb.ld_reg = 4'd1; wb.ld_data = 16'h00AA;
    wb.alu_valid = 1; wb.alu_reg = 4'd2; wb.alu_data = 16'h00BB;
    #1 chk("prio_alu_ready", wb.alu_ready, 0);
    step;
    wb.ld_valid = 0;
    step;
    wb.alu_valid = 0;
    chk("prio_s1_rw", wb.RegWrite, 1);
    chk("prio_s1_reg", wb.writeReg, 1);
    chk("prio_s1_val", wb.writeValue, 16'h00AA);
    step;
    chk("prio_s2_rw", wb.RegWrite, 1);
    chk("prio_s2_reg", wb.writeReg, 2);
    chk("prio_s2_val", wb.writeValue, 16'h00BB);
    step;
    chk("prio_done", wb.RegWrite, 0);

    // Protected destinations are swallowed
    wb.alu_valid = 1; wb.alu_reg = 4'd9; wb.alu_data = 16'h1234;
    step;
    wb.alu_reg = 4'd13; wb.alu_data = 16'h5555;
    step;
    chk("prot_drop", wb.drop_cnt, 2);
    chk("prot_norw", wb.RegWrite, 0);
    wb.alu_reg = 4'd0; wb.alu_data = 16'h0001;
    step;
    wb.alu_valid = 0;
    step;
    chk("prot_r0_rw", wb.RegWrite, 1);
    chk("prot_r0_reg", wb.writeReg, 0);
    chk("prot_r0_val", wb.writeValue, 16'h0001);
    step;

    // Fill under init, then drain in order
    wb.init = 1; wb.ld_valid = 1;
    for (int i = 0; i < 4; i++) begin
      wb.ld_reg = 4'(i + 1); wb.ld_data = 16'h0100 + 16'(i);
      step;
    end
    chk("full_ld_ready", wb.ld_ready, 0);
    chk("full_alu_ready", wb.alu_ready, 0);
    chk("full_norw", wb.RegWrite, 0);
    wb.ld_valid = 0; wb.init = 0;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("drain_rw", wb.RegWrite, 1);
      chk("drain_reg", wb.writeReg, 32'(i + 1));
      chk("drain_val", wb.writeValue, 32'h0100 + 32'(i));
    end
    chk("drain_ld_ready", wb.ld_ready, 1);
    chk("drain_alu_ready", wb.alu_ready, 1);
    step;
    chk("drain_idle", wb.pending, 0);

    // Drop counter saturation
    wb.alu_valid = 1; wb.alu_reg = 4'd7;
    for (int i = 0; i < 260; i++) step;
    wb.alu_valid = 0;
    chk("sat_drop", wb.drop_cnt, 255);

    // Reset in the middle of a burst
    wb.init = 1; wb.ld_valid = 1;
    for (int i = 0; i < 3; i++) begin
      wb.ld_reg = 4'(i + 1); wb.ld_data = 16'h0200 + 16'(i);
      step;
    end
    wb.ld_valid = 0; wb.init = 0;
    step;
    chk("mid_rw_before", wb.RegWrite, 1);
    RST_N = 0;
    #1;
    chk("mid_rw_async", wb.RegWrite, 0);
    chk("mid_drop_async", wb.drop_cnt, 0);
    @(posedge CLK); #3 RST_N = 1;
    step;
    chk("mid_pending", wb.pending, 0);
    chk("mid_drop", wb.drop_cnt, 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      wb.ld_valid  = ($urandom_range(0, 2) == 0);
      wb.ld_reg    = 4'($urandom_range(0, 15));
      wb.ld_data   = 16'($urandom);
      wb.alu_valid = ($urandom_range(0, 1) == 0);
      wb.alu_reg   = 4'($urandom_range(0, 15));
      wb.alu_data  = 16'($urandom);
      wb.init      = ($urandom_range(0, 7) == 0);
      wb.fwd_reg   = 4'($urandom_range(0, 15));
      step;
    end
    idle_in;
    repeat (8) step;

    // Forwarding lookup
    wb.init = 1; wb.ld_valid = 1;
    wb.ld_reg = 4'd3; wb.ld_data = 16'h0011;
    step;
    wb.ld_data = 16'h0022;
    step;
    wb.ld_valid = 0;
    wb.fwd_reg = 4'd3;
    #1;
`ifdef WB_FWD_EN
    chk("fwd_hit3", wb.fwd_hit, 1);
    chk("fwd_data3", wb.fwd_data, 16'h0022);
`else
    chk("fwd_off_hit", wb.fwd_hit, 0);
    chk("fwd_off_data", wb.fwd_data, 0);
`endif
    wb.fwd_reg = 4'd5;
    #1 chk("fwd_hit5", wb.fwd_hit, 0);
    wb.init = 0;
    repeat (4) step;
    chk("end_pending", wb.pending, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
